sync_fifo_ctrl: RTL
===================

# sync_fifo_ctrl

Parameterised single-clock FIFO controller with integrated storage. It is the same-domain successor to the dual-clock FIFO controller and buffers AHB-to-SPI transactions, 41-bit by default, where producer and consumer share one clock. Beyond full/empty it provides:
- a fill-level count and programmable almost-full/almost-empty thresholds;
- selectable standard or first-word-fall-through (FWFT) read mode;
- synchronous flush and sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 41, width of each stored word
- ADDR_WIDTH, 4, depth DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- AFULL_LEVEL, 14, almost_full asserted when level >= AFULL_LEVEL; legal range 1..DEPTH
- AEMPTY_LEVEL, 2, almost_empty asserted when level <= AEMPTY_LEVEL; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word fall-through

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous flush
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a popped word (standard mode); equals !empty (FWFT mode)
- full, empty, almost_full, almost_empty  out  1  status flags
- level  out  ADDR_WIDTH+1  current number of stored words, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Storage: internal array of DEPTH x DATA_WIDTH. Memory contents are never reset.
- Pointers: binary wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array; both pointers wrap modulo 2^(ADDR_WIDTH+1).
- Level: level = (wr_ptr - rd_ptr) mod 2^(ADDR_WIDTH+1).
- Flags are combinational from the pointer registers:
  - full = (level == DEPTH)
  - empty = (level == 0)
  - almost_full = (level >= AFULL_LEVEL)
  - almost_empty = (level <= AEMPTY_LEVEL)
- Push and pop acceptance:
  - Push accepted iff wr_en && !full: data is written to wr_ptr and wr_ptr increments.
  - Pop accepted iff rd_en && !empty: rd_ptr increments.
- Simultaneous push and pop:
  - Non-empty and non-full: both are accepted and level is unchanged.
  - Empty: only the push is accepted, and underflow is set.
  - Full: only the pop is accepted, and overflow is set. No write-through in either case.
- Error flags:
  - overflow is set on wr_en && full.
  - underflow is set on rd_en && empty.
  - Both hold until clr or reset.
- Standard mode (FWFT=0):
  - On an accepted pop, rd_data is loaded from the array at rd_ptr, and rd_valid is 1 for the following cycle.
  - rd_valid is 0 after any cycle without an accepted pop.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data presents the array word at rd_ptr combinationally whenever !empty, and is forced to 0 when empty.
  - rd_valid = !empty.
  - rd_en acknowledges the displayed word and advances to the next.
- Flush (clr=1): at the edge, wr_ptr, rd_ptr, overflow, underflow and rd_valid return to 0. clr overrides wr_en and rd_en in the same cycle, and neither is accepted.
- Reset (rst_n=0):
  - Immediately, independent of clk, all registers go to their reset values.
  - A push or pop in flight on the asserting edge is discarded.
  - rst_n deassertion must be synchronous to clk (external synchroniser).
- Reset values of outputs:
  - level=0, empty=1, almost_empty=1, full=0
  - almost_full=0 (since AFULL_LEVEL >= 1)
  - overflow=0, underflow=0, rd_valid=0, rd_data=0

## Timing
- Flags and level reflect the pointers after the most recent edge; there is no added latency beyond that edge.
  - A push at edge N makes empty=0 and level=1 visible after edge N.
- Standard-mode read latency is 1 cycle: rd_en accepted at edge N gives rd_data and rd_valid valid after edge N, until edge N+1.
- FWFT-mode read latency from a push into an empty FIFO is 1 cycle: the word pushed at edge N appears on rd_data after edge N, with no rd_en needed.
- Throughput: one push and one pop per cycle, sustained.
- Inputs are sampled only on the rising edge of clk; there are no combinational paths from wr_en or rd_en to any output.

## Test plan
- Reset/fill/drain (DEPTH=16, standard mode):
  - Assert rst_n=0 mid-burst → all outputs take their reset values immediately.
  - Push 16 words 0x0..0xF → level=16, full=1, almost_full=1 from level 14.
  - Pop 16 → rd_data 0x0..0xF in order, each 1 cycle after its rd_en; then empty=1.
- Overflow/underflow:
  - At full, wr_en=1 with data 0xAA → level stays 16, overflow=1 and stays 1; the word 0xAA is never read.
  - At empty, rd_en=1 → underflow=1, rd_valid=0.
  - clr → both flags 0.
- Simultaneous push/pop:
  - At level=5, 20 cycles of wr_en=rd_en=1 → level stays 5 and data order is preserved.
  - Same stimulus at level=0 → level becomes 1 and underflow=1.
  - Same stimulus at level=16 → level becomes 15 and overflow=1.
- Wrap-around:
  - Push/pop 40 words through DEPTH=16 with random gaps → all data matches the scoreboard and level is always 0..16.
- FWFT mode (FWFT=1):
  - Push 0x123 into empty FIFO → rd_data=0x123 and rd_valid=1 the next cycle without rd_en.
  - rd_en=1 → next word shown, or rd_valid=0 and rd_data=0 when the FIFO becomes empty.
- Flush:
  - At level=9 with wr_en=rd_en=1, assert clr for 1 cycle → level=0, empty=1, no push or pop accepted.
  - Subsequent push of 0x55 → read back as 0x55.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with integrated storage.
// Buffers same-clock producer/consumer traffic and reports fill level,
// programmable almost-full/almost-empty, and sticky overflow/underflow.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   async assert, active-low reset (release synchronised externally)
//   clr          in   synchronous flush, overrides wr_en/rd_en
//   wr_en        in   push request
//   wr_data      in   [DATA_WIDTH] push data
//   rd_en        in   pop request
//   rd_data      out  [DATA_WIDTH] read data (registered, or fall-through when FWFT=1)
//   rd_valid     out  popped word present (standard) / !empty (FWFT)
//   full, empty, almost_full, almost_empty  out  status flags from pointers
//   level        out  [ADDR_WIDTH+1] stored word count, 0..DEPTH
//   overflow     out  sticky: wr_en while full
//   underflow    out  sticky: rd_en while empty
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH   = 41,
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_LEVEL  = 14,
   parameter int AEMPTY_LEVEL = 2,
   parameter bit FWFT         = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
   localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [PW-1:0] level_w;
   logic          full_w, empty_w;
   logic          push_w, pop_w;

   // Extra pointer bit makes full and empty distinguishable by subtraction.
   assign level_w = wr_ptr_q - rd_ptr_q;
   assign full_w  = (level_w == DEPTH_L);
   assign empty_w = (level_w == '0);

   // rst_n gating keeps a write on the asserting edge out of the array.
   assign push_w = wr_en && !full_w  && !clr && rst_n;
   assign pop_w  = rd_en && !empty_w && !clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_en && full_w)  ovf_d = 1'b1;
         if (rd_en && empty_w) udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_w) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
   end

   generate
      if (FWFT == 1'b0) begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                  rd_valid_q, rd_valid_d;

         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = pop_w;
            if (pop_w) rd_data_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end else begin : g_fwft
         // Head word shown directly from the array; zeroed when nothing is stored.
         assign rd_data  = empty_w ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         assign rd_valid = !empty_w;
      end
   endgenerate

   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (level_w >= AFULL_L);
   assign almost_empty = (level_w <= AEMPTY_L);
   assign level        = level_w;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
